// File: rtl/program_loader_pkg.sv
// Shared definitions for the framed program loader: FSM states, frame constants.
// Frame: SYNC | TARGET | CNT_HI | CNT_LO | CNT*4 payload bytes (LE) | XOR checksum.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TARGET,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [7:0] SYNC     = 8'hA5;
  localparam logic [7:0] TGT_IMEM = 8'h00;
  localparam logic [7:0] TGT_DMEM = 8'h01;

  // A frame may fill the whole memory but never run past its end.
  function automatic logic cnt_too_big(input logic [15:0] cnt, input int addr_w);
    return {1'b0, cnt} > (17'd1 << addr_w);
  endfunction

endpackage

// File: rtl/program_loader_word_packer.sv
// Assembles accepted bytes LSB-first into 32-bit words; word_vld pulses with the 4th byte.
// Zero latency to word_vld (combinational on the 4th byte); never stalls the byte stream.
module word_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  logic [1:0]  idx;
  logic [23:0] shift;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx   <= 2'd0;
      shift <= 24'd0;
    end else if (byte_vld) begin
      idx   <= idx + 2'd1;
      shift <= {byte_dat, shift[23:8]};
    end
  end

  assign word_vld = byte_vld && (idx == 2'd3);
  assign word_dat = {byte_dat, shift};

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader writing 32-bit words into instruction/data memory; holds the core until done.
// Write strobe one cycle after the 4th byte of a word; byte_ready_o drops only in DONE/ERR.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic              mem_sel_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              error_o
);

  state_t      state, state_nxt;
  logic        acc;
  logic [7:0]  cnt_hi;
  logic [15:0] cnt;
  logic [15:0] cnt_in;
  logic [15:0] word_cnt;
  logic [7:0]  csum;
  logic        pk_vld;
  logic [31:0] pk_dat;
  logic        last_word;

  assign acc       = byte_valid_i && byte_ready_o;
  assign cnt_in    = {cnt_hi, byte_i};
  assign last_word = pk_vld && (word_cnt == cnt - 16'd1);

  word_packer u_packer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .byte_vld (acc && (state == ST_DATA)),
    .byte_dat (byte_i),
    .word_vld (pk_vld),
    .word_dat (pk_dat)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (acc) begin
      case (state)
        ST_IDLE:   if (byte_i == SYNC) state_nxt = ST_TARGET;
        ST_TARGET: state_nxt = (byte_i == TGT_IMEM || byte_i == TGT_DMEM) ? ST_CNT_HI : ST_ERR;
        ST_CNT_HI: state_nxt = ST_CNT_LO;
        ST_CNT_LO: begin
          if (cnt_too_big(cnt_in, ADDR_W)) state_nxt = ST_ERR;
          else if (cnt_in == 16'd0)        state_nxt = ST_CHECK;
          else                             state_nxt = ST_DATA;
        end
        ST_DATA:   if (last_word) state_nxt = ST_CHECK;
        ST_CHECK:  state_nxt = (byte_i == csum) ? ST_DONE : ST_ERR;
        default:   state_nxt = state;
      endcase
    end
  end

  always_comb begin
    byte_ready_o = !(state == ST_DONE || state == ST_ERR);
    cpu_hold_o   = (state != ST_DONE);
    done_o       = (state == ST_DONE);
    error_o      = (state == ST_ERR);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_we_o   <= 1'b0;
      mem_sel_o  <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      cnt_hi     <= 8'd0;
      cnt        <= 16'd0;
      word_cnt   <= 16'd0;
      csum       <= 8'd0;
    end else begin
      mem_we_o <= pk_vld;
      if (pk_vld) begin
        mem_addr_o <= word_cnt[ADDR_W-1:0];
        mem_data_o <= pk_dat;
        word_cnt   <= word_cnt + 16'd1;
      end
      if (acc) begin
        case (state)
          ST_TARGET: if (byte_i == TGT_IMEM || byte_i == TGT_DMEM) mem_sel_o <= byte_i[0];
          ST_CNT_HI: cnt_hi <= byte_i;
          ST_CNT_LO: cnt    <= cnt_in;
          ST_DATA:   csum   <= csum ^ byte_i;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected memory writes queued at stimulus time, checked at the write port.
module tb_program_loader;

  typedef struct packed {
    logic        sel;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic        mem_sel_o;
  logic [7:0]  mem_addr_o;
  logic [31:0] mem_data_o;
  logic        cpu_hold_o;
  logic        done_o;
  logic        error_o;

  int  tests = 0;
  int  fails = 0;
  int  nwr   = 0;
  bit  gaps  = 0;
  wr_t sb[$];

  program_loader #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_sel_o    (mem_sel_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .cpu_hold_o   (cpu_hold_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_we_o) begin
      wr_t got, exp;
      got = '{sel: mem_sel_o, addr: mem_addr_o, data: mem_data_o};
      nwr++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $error("FAIL unexpected_write: observed %0h expected no write", got);
      end else begin
        exp = sb.pop_front();
        assert (got === exp) else begin
          fails++;
          $error("FAIL write: observed %0h expected %0h", got, exp);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        byte_valid_i = 1'b0;
      end
    end
    @(negedge clk);
    byte_i       = b;
    byte_valid_i = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      byte_valid_i = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    byte_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] xor_word(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  // Full frame of up to two words; csum_flip corrupts the checksum byte.
  task automatic run_frame(input logic [7:0] tgt, input int n, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [7:0] csum_flip, input string tag);
    logic [31:0] w[2];
    logic [7:0]  cs;
    w[0] = w0;
    w[1] = w1;
    cs   = 8'h00;
    for (int i = 0; i < n; i++) begin
      cs ^= xor_word(w[i]);
      sb.push_back('{sel: tgt[0], addr: 8'(i), data: w[i]});
    end
    send(8'hA5); send(tgt); send(8'h00); send(8'(n));
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) send(w[i][8*k +: 8]);
    send(cs ^ csum_flip);
    chk({tag, "_hold_before_csum"}, 64'(cpu_hold_o), 64'd1);
    idle(3);
    chk({tag, "_all_writes_seen"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int base;
    rst          = 1'b1;
    byte_i       = 8'h00;
    byte_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(byte_ready_o), 64'd1);
    chk("rst_we",    64'(mem_we_o),     64'd0);
    chk("rst_sel",   64'(mem_sel_o),    64'd0);
    chk("rst_addr",  64'(mem_addr_o),   64'd0);
    chk("rst_data",  64'(mem_data_o),   64'd0);
    chk("rst_hold",  64'(cpu_hold_o),   64'd1);
    chk("rst_done",  64'(done_o),       64'd0);
    chk("rst_err",   64'(error_o),      64'd0);
    rst = 1'b0;

    // Good imem frame.
    run_frame(8'h00, 2, 32'h12345678, 32'hDEADBEEF, 8'h00, "t1");
    chk("t1_done",  64'(done_o),       64'd1);
    chk("t1_hold",  64'(cpu_hold_o),   64'd0);
    chk("t1_ready", 64'(byte_ready_o), 64'd0);
    chk("t1_err",   64'(error_o),      64'd0);
    send(8'hA5);
    idle(2);
    chk("t1_sticky_done", 64'(done_o), 64'd1);

    // Same frame to dmem.
    do_reset();
    run_frame(8'h01, 2, 32'h12345678, 32'hDEADBEEF, 8'h00, "t2");
    chk("t2_done", 64'(done_o), 64'd1);
    chk("t2_sel",  64'(mem_sel_o), 64'd1);

    // Bad checksum: words land, frame rejected.
    do_reset();
    run_frame(8'h00, 2, 32'h12345678, 32'hDEADBEEF, 8'h01, "t3");
    chk("t3_err",   64'(error_o),      64'd1);
    chk("t3_done",  64'(done_o),       64'd0);
    chk("t3_hold",  64'(cpu_hold_o),   64'd1);
    chk("t3_ready", 64'(byte_ready_o), 64'd0);

    // Leading junk, then a good frame.
    do_reset();
    send(8'h00); send(8'hFF); send(8'h5A);
    run_frame(8'h00, 2, 32'hCAFEF00D, 32'h0BADC0DE, 8'h00, "t4");
    chk("t4_done", 64'(done_o), 64'd1);

    // Illegal target.
    do_reset();
    base = nwr;
    send(8'hA5); send(8'h07); send(8'h00); send(8'h01);
    idle(3);
    chk("t4b_err",      64'(error_o),     64'd1);
    chk("t4b_no_write", 64'(nwr - base),  64'd0);

    // Count just past memory size.
    do_reset();
    send(8'hA5); send(8'h00); send(8'h01); send(8'h01);
    idle(2);
    chk("t5_cnt_over_err", 64'(error_o), 64'd1);
    chk("t5_cnt_over_ready", 64'(byte_ready_o), 64'd0);

    // Empty frame.
    do_reset();
    base = nwr;
    run_frame(8'h01, 0, 32'h0, 32'h0, 8'h00, "t5b");
    chk("t5b_done",     64'(done_o),    64'd1);
    chk("t5b_no_write", 64'(nwr - base), 64'd0);

    // Gapped stream, reset after 6 payload bytes, then full reload.
    do_reset();
    gaps = 1;
    base = nwr;
    sb.push_back('{sel: 1'b0, addr: 8'd0, data: 32'h44332211});
    send(8'hA5); send(8'h00); send(8'h00); send(8'h02);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
    idle(2);
    chk("t6_one_write_pre_reset", 64'(nwr - base), 64'd1);
    do_reset();
    chk("t6_hold_after_rst",  64'(cpu_hold_o),   64'd1);
    chk("t6_ready_after_rst", 64'(byte_ready_o), 64'd1);
    chk("t6_done_after_rst",  64'(done_o),       64'd0);
    run_frame(8'h00, 2, 32'hA1B2C3D4, 32'h01020304, 8'h00, "t6");
    chk("t6_done", 64'(done_o), 64'd1);
    chk("t6_total_writes", 64'(nwr - base), 64'd3);
    gaps = 0;

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
